// File: rtl/xadac_stage_vload_pkg.sv
// Shared types for the xadac vector-load stage: request/response widths, slot state and entry layout.
// Pure declarations, no logic.
package xadac_stage_vload_pkg;

    localparam int IdWidth   = 2;
    localparam int XLEN      = 32;
    localparam int NoEntries = 2 ** IdWidth;

    typedef logic [IdWidth-1:0] IdT;
    typedef logic [XLEN-1:0]    XlenT;
    typedef logic [31:0]        AddrT;
    typedef logic [127:0]       VectorT;
    typedef logic [4:0]         ImmT;

    localparam int VecBits    = $bits(VectorT);
    localparam int VecBytes   = VecBits / 8;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } slot_state_e;

    typedef struct packed {
        slot_state_e state;
        AddrT        addr;
        ImmT         imm;
        VectorT      data;
    } entry_t;

    // Vector loads are always fetched from a VecBytes-aligned address.
    function automatic AddrT align_addr(input XlenT a);
        return AddrT'(a) & ~AddrT'(VecBytes - 1);
    endfunction

endpackage

// File: rtl/xadac_stage_vload_if.sv
// Request/response channel into the load stage and the OBI memory channel out of it.
// Master drives requests; slave drives responses.
interface xadac_stage_vload_if;
    import xadac_stage_vload_pkg::*;

    logic   req_valid;
    logic   req_ready;
    IdT     req_id;
    XlenT   req_rs1;
    ImmT    req_imm;
    logic   resp_valid;
    logic   resp_ready;
    IdT     resp_id;
    VectorT resp_vd;
    XlenT   resp_rd;

    modport master (output req_valid, req_id, req_rs1, req_imm, resp_ready,
                    input  req_ready, resp_valid, resp_id, resp_vd, resp_rd);
    modport slave  (input  req_valid, req_id, req_rs1, req_imm, resp_ready,
                    output req_ready, resp_valid, resp_id, resp_vd, resp_rd);
endinterface

interface xadac_obi_if;
    import xadac_stage_vload_pkg::*;

    logic                req;
    logic                gnt;
    AddrT                addr;
    logic                we;
    logic [VecBytes-1:0] be;
    VectorT              wdata;
    IdT                  aid;
    logic                rvalid;
    logic                rready;
    IdT                  rid;
    VectorT              rdata;

    modport master (output req, addr, we, be, wdata, aid, rready,
                    input  gnt, rvalid, rid, rdata);
    modport slave  (input  req, addr, we, be, wdata, aid, rready,
                    output gnt, rvalid, rid, rdata);
endinterface

// File: rtl/xadac_prio_pick.sv
// Lowest-index picker over an N-bit request mask; purely combinational, zero latency.
// No backpressure: any=0 when the mask is empty.
module xadac_prio_pick #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] mask,
    output logic [W-1:0] idx,
    output logic         any
);
    always_comb begin
        idx = '0;
        any = 1'b0;
        // Walk downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/xadac_stage_vload.sv
// Out-of-order vector load stage: one scoreboard slot per id, OBI fetch, tail-masked tagged response.
// Latency: accept->obi.req 2 cycles, R beat->resp_valid 1 cycle; OBI A and resp outputs held until gnt / resp_ready.
module xadac_stage_vload
    import xadac_stage_vload_pkg::*;
#(
    parameter int LaneWidth = 8,
    parameter bit ZeroTail  = 1'b1
) (
    input  logic          clk,
    input  logic          rstn,
    xadac_stage_vload_if.slave slv,
    xadac_obi_if.master        obi
);
    localparam int NLanes = VecBits / LaneWidth;

    entry_t entry_q [NoEntries];
    entry_t entry_d [NoEntries];
    logic   obi_req_q, obi_req_d;
    AddrT   obi_addr_q, obi_addr_d;
    IdT     obi_aid_q, obi_aid_d;
    logic   resp_valid_q, resp_valid_d;
    IdT     resp_id_q, resp_id_d;
    VectorT resp_vd_q, resp_vd_d;

    logic                 a_gnt, r_hit, resp_hs, req_hs;
    logic [NoEntries-1:0] issue_mask, done_mask;
    IdT                   issue_idx, done_idx;
    logic                 issue_any, done_any;
    VectorT               r_data;

    // Handshake decode, pick masks and tail masking of the incoming R beat.
    always_comb begin
        a_gnt   = obi_req_q && obi.gnt;
        r_hit   = obi.rvalid && (entry_q[obi.rid].state == WAIT);
        resp_hs = resp_valid_q && slv.resp_ready;
        req_hs  = slv.req_valid &&
                  ((entry_q[slv.req_id].state == FREE) || (resp_hs && (resp_id_q == slv.req_id)));
        for (int i = 0; i < NoEntries; i++) begin
            issue_mask[i] = (entry_q[i].state == ISSUE) && !(a_gnt && (obi_aid_q == IdT'(i)));
            done_mask[i]  = ((entry_q[i].state == DONE) && !(resp_hs && (resp_id_q == IdT'(i))))
                          || (r_hit && (obi.rid == IdT'(i)));
        end
        r_data = obi.rdata;
        if (ZeroTail) begin
            for (int l = 0; l < NLanes; l++) begin
                if (l >= int'(entry_q[obi.rid].imm)) r_data[l*LaneWidth +: LaneWidth] = '0;
            end
        end
    end

    xadac_prio_pick #(.N(NoEntries)) u_pick_issue (.mask(issue_mask), .idx(issue_idx), .any(issue_any));
    xadac_prio_pick #(.N(NoEntries)) u_pick_resp  (.mask(done_mask),  .idx(done_idx),  .any(done_any));

    always_comb begin
        entry_d = entry_q;
        if (a_gnt) entry_d[obi_aid_q].state = WAIT;
        if (r_hit) begin
            entry_d[obi.rid].state = DONE;
            entry_d[obi.rid].data  = r_data;
        end
        if (resp_hs) entry_d[resp_id_q].state = FREE;
        // Applied after the free so a slot released this cycle can be re-accepted at once.
        if (req_hs) begin
            entry_d[slv.req_id].state = ISSUE;
            entry_d[slv.req_id].addr  = align_addr(slv.req_rs1);
            entry_d[slv.req_id].imm   = slv.req_imm;
        end

        obi_req_d  = obi_req_q;
        obi_addr_d = obi_addr_q;
        obi_aid_d  = obi_aid_q;
        if (!obi_req_q || a_gnt) begin
            obi_req_d = issue_any;
            if (issue_any) begin
                obi_addr_d = entry_q[issue_idx].addr;
                obi_aid_d  = issue_idx;
            end
        end

        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_vd_d    = resp_vd_q;
        if (!resp_valid_q || resp_hs) begin
            resp_valid_d = done_any;
            if (done_any) begin
                resp_id_d = done_idx;
                resp_vd_d = (r_hit && (obi.rid == done_idx)) ? r_data : entry_q[done_idx].data;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NoEntries; i++) entry_q[i] <= '0;
            obi_req_q    <= 1'b0;
            obi_addr_q   <= '0;
            obi_aid_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_vd_q    <= '0;
        end else begin
            entry_q      <= entry_d;
            obi_req_q    <= obi_req_d;
            obi_addr_q   <= obi_addr_d;
            obi_aid_q    <= obi_aid_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_vd_q    <= resp_vd_d;
        end
    end

    assign slv.req_ready  = req_hs;
    assign slv.resp_valid = resp_valid_q;
    assign slv.resp_id    = resp_id_q;
    assign slv.resp_vd    = resp_vd_q;
    assign slv.resp_rd    = '0;
    assign obi.req        = obi_req_q;
    assign obi.addr       = obi_addr_q;
    assign obi.aid        = obi_aid_q;
    assign obi.we         = 1'b0;
    assign obi.be         = '1;
    assign obi.wdata      = '0;
    assign obi.rready     = 1'b1;

    // A beat for a slot that is not waiting is dropped; flag it so the memory side can be debugged.
    ap_stray_r: assert property (@(posedge clk) disable iff (!rstn)
        obi.rvalid |-> (entry_q[obi.rid].state == WAIT))
        else $warning("R beat for id %0d with no outstanding load, dropped", obi.rid);

endmodule
